// File: rtl/hls_pr_axil_ctrl_slave.sv
// AXI4-Lite control slave for an HLS kernel: start/done/idle handshake, IRQ enable/status, four 32-bit args.
// Latency: write visible and bvalid high the cycle after both AW and W are accepted; rvalid the cycle after AR.
// Backpressure: AW/W each stall while their beat is held or B is pending; AR stalls while R is pending.
// Ports: clk/reset_n; s_axil_* AXI4-Lite slave; ap_start/ap_done/ap_ready/ap_idle kernel handshake;
//        arg0..arg3 kernel arguments; interrupt level IRQ to the static region.
module hls_pr_axil_ctrl_slave #(
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] s_axil_awaddr,
    input  logic [2:0]  s_axil_awprot,
    input  logic        s_axil_awvalid,
    output logic        s_axil_awready,
    input  logic [31:0] s_axil_wdata,
    input  logic [3:0]  s_axil_wstrb,
    input  logic        s_axil_wvalid,
    output logic        s_axil_wready,
    output logic [1:0]  s_axil_bresp,
    output logic        s_axil_bvalid,
    input  logic        s_axil_bready,
    input  logic [31:0] s_axil_araddr,
    input  logic [2:0]  s_axil_arprot,
    input  logic        s_axil_arvalid,
    output logic        s_axil_arready,
    output logic [31:0] s_axil_rdata,
    output logic [1:0]  s_axil_rresp,
    output logic        s_axil_rvalid,
    input  logic        s_axil_rready,
    output logic        ap_start,
    input  logic        ap_done,
    input  logic        ap_ready,
    input  logic        ap_idle,
    output logic [31:0] arg0,
    output logic [31:0] arg1,
    output logic [31:0] arg2,
    output logic [31:0] arg3,
    output logic        interrupt
);
    localparam int IDX_W = ADDR_W - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t          wstate;
    rstate_t          rstate;
    logic             aw_held, w_held;
    logic [IDX_W-1:0] awidx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;

    logic             done_latch, ready_latch, auto_restart, gie;
    logic [1:0]       ier, isr;
    logic [31:0]      arg_r [4];

    logic             aw_hs, w_hs, ar_hs, commit, wr_err, rd_err, wr_reg, rd_ctrl;
    logic             we_ctrl, we_gie, we_ier, we_isr;
    logic [IDX_W-1:0] widx, ridx;
    logic [31:0]      wd, rd_val;
    logic [3:0]       ws;

    // Address bits outside the decoded window and the prot fields carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_axil_awaddr[31:ADDR_W], s_axil_awaddr[1:0], s_axil_awprot,
                           s_axil_araddr[31:ADDR_W], s_axil_araddr[1:0], s_axil_arprot};

    assign s_axil_awready = !aw_held && !s_axil_bvalid;
    assign s_axil_wready  = !w_held && !s_axil_bvalid;
    assign s_axil_arready = !s_axil_rvalid;

    assign aw_hs = s_axil_awvalid && s_axil_awready;
    assign w_hs  = s_axil_wvalid && s_axil_wready;
    assign ar_hs = s_axil_arvalid && s_axil_arready;

    // A beat arriving this cycle is used directly, so a write whose last beat lands
    // this cycle commits on the same edge instead of waiting for the held copy.
    assign widx   = aw_held ? awidx_q : s_axil_awaddr[ADDR_W-1:2];
    assign wd     = w_held ? wdata_q : s_axil_wdata;
    assign ws     = w_held ? wstrb_q : s_axil_wstrb;
    assign commit = (wstate == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_err = |widx[IDX_W-1:3];
    assign wr_reg = commit && !wr_err;

    assign we_ctrl = wr_reg && (widx[2:0] == 3'd0) && ws[0];
    assign we_gie  = wr_reg && (widx[2:0] == 3'd1) && ws[0];
    assign we_ier  = wr_reg && (widx[2:0] == 3'd2) && ws[0];
    assign we_isr  = wr_reg && (widx[2:0] == 3'd3) && ws[0];

    assign ridx    = s_axil_araddr[ADDR_W-1:2];
    assign rd_err  = |ridx[IDX_W-1:3];
    assign rd_ctrl = ar_hs && !rd_err && (ridx[2:0] == 3'd0);

    assign arg0 = arg_r[0];
    assign arg1 = arg_r[1];
    assign arg2 = arg_r[2];
    assign arg3 = arg_r[3];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // Read mux sees current register values, so a read accepted alongside a
    // write commit returns the pre-write contents.
    always_comb begin
        rd_val = 32'd0;
        if (!rd_err) begin
            case (ridx[2:0])
                3'd0: rd_val = {24'd0, auto_restart, 3'd0, ready_latch, ap_idle, done_latch, ap_start};
                3'd1: rd_val = {31'd0, gie};
                3'd2: rd_val = {30'd0, ier};
                3'd3: rd_val = {30'd0, isr};
                3'd4: rd_val = arg_r[0];
                3'd5: rd_val = arg_r[1];
                3'd6: rd_val = arg_r[2];
                default: rd_val = arg_r[3];
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wstate        <= W_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            awidx_q       <= '0;
            wdata_q       <= 32'd0;
            wstrb_q       <= 4'd0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                awidx_q <= s_axil_awaddr[ADDR_W-1:2];
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= s_axil_wdata;
                wstrb_q <= s_axil_wstrb;
            end
            case (wstate)
                W_IDLE: if (commit) begin
                    wstate        <= W_RESP;
                    s_axil_bvalid <= 1'b1;
                    s_axil_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
                end
                W_RESP: if (s_axil_bready) begin
                    wstate        <= W_IDLE;
                    s_axil_bvalid <= 1'b0;
                    aw_held       <= 1'b0;
                    w_held        <= 1'b0;
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rstate        <= R_IDLE;
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= 32'd0;
            s_axil_rresp  <= RESP_OKAY;
        end else begin
            case (rstate)
                R_IDLE: if (ar_hs) begin
                    rstate        <= R_DATA;
                    s_axil_rvalid <= 1'b1;
                    s_axil_rdata  <= rd_val;
                    s_axil_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
                end
                R_DATA: if (s_axil_rready) begin
                    rstate        <= R_IDLE;
                    s_axil_rvalid <= 1'b0;
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    // Kernel-side events always win over software clears in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ap_start     <= 1'b0;
            auto_restart <= 1'b0;
            done_latch   <= 1'b0;
            ready_latch  <= 1'b0;
            gie          <= 1'b0;
            ier          <= 2'd0;
            isr          <= 2'd0;
            interrupt    <= 1'b0;
            for (int i = 0; i < 4; i++) arg_r[i] <= 32'd0;
        end else begin
            if (we_ctrl) auto_restart <= wd[7];
            if (we_ctrl && wd[0]) ap_start <= 1'b1;
            else if (ap_ready && !auto_restart) ap_start <= 1'b0;
            done_latch  <= ap_done || (done_latch && !rd_ctrl);
            ready_latch <= ap_ready || (ready_latch && !rd_ctrl);
            if (we_gie) gie <= wd[0];
            if (we_ier) ier <= wd[1:0];
            isr <= {ap_ready, ap_done} | (isr & ~(we_isr ? wd[1:0] : 2'b00));
            for (int i = 0; i < 4; i++) begin
                if (wr_reg && widx[2] && (widx[1:0] == i[1:0])) arg_r[i] <= merge(arg_r[i], wd, ws);
            end
            interrupt <= gie && |(isr & ier);
        end
    end
endmodule

// File: tb/tb_hls_pr_axil_ctrl_slave.sv
// Directed bench for hls_pr_axil_ctrl_slave with a response scoreboard.
// Stimulus tasks push expected B/R responses; a negedge monitor pops them on each handshake.
// Direct checks cover reset values, latency, kernel handshake, interrupt timing and async reset.
module tb_hls_pr_axil_ctrl_slave;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] s_axil_awaddr = '0;
    logic [2:0]  s_axil_awprot = '0;
    logic        s_axil_awvalid = 1'b0;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata = '0;
    logic [3:0]  s_axil_wstrb = '0;
    logic        s_axil_wvalid = 1'b0;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready = 1'b1;
    logic [31:0] s_axil_araddr = '0;
    logic [2:0]  s_axil_arprot = '0;
    logic        s_axil_arvalid = 1'b0;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready = 1'b1;
    logic        ap_start;
    logic        ap_done = 1'b0;
    logic        ap_ready = 1'b0;
    logic        ap_idle = 1'b0;
    logic [31:0] arg0, arg1, arg2, arg3;
    logic        interrupt;

    int checks = 0;
    int errors = 0;
    logic [1:0]  bq [$];
    logic [33:0] rq [$];

    hls_pr_axil_ctrl_slave #(.ADDR_W(12)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .ap_start(ap_start), .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle),
        .arg0(arg0), .arg1(arg1), .arg2(arg2), .arg3(arg3),
        .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ready();
        ap_ready = 1'b1;
        step();
        ap_ready = 1'b0;
    endtask

    // Let any B beat still pending with bready high drain first, so the
    // accept edge of this write is the first edge after valids rise.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] resp, input bit pulse_done);
        logic aw_hs, w_hs;
        for (int i = 0; i < 20 && s_axil_bvalid && s_axil_bready; i++) step();
        bq.push_back(resp);
        s_axil_awaddr = addr; s_axil_awvalid = 1'b1;
        s_axil_wdata = data; s_axil_wstrb = strb; s_axil_wvalid = 1'b1;
        if (pulse_done) ap_done = 1'b1;
        for (int i = 0; i < 50 && (s_axil_awvalid || s_axil_wvalid); i++) begin
            aw_hs = s_axil_awvalid && s_axil_awready;
            w_hs  = s_axil_wvalid && s_axil_wready;
            step();
            ap_done = 1'b0;
            if (aw_hs) s_axil_awvalid = 1'b0;
            if (w_hs)  s_axil_wvalid = 1'b0;
        end
        if (s_axil_awvalid || s_axil_wvalid) begin
            checks++; errors++;
            $display("FAIL write_timeout addr 0x%08h: AW/W not accepted within budget", addr);
            s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                            input bit pulse_done);
        logic hs;
        for (int i = 0; i < 20 && s_axil_rvalid && s_axil_rready; i++) step();
        rq.push_back({resp, data});
        s_axil_araddr = addr; s_axil_arvalid = 1'b1;
        if (pulse_done) ap_done = 1'b1;
        hs = 1'b0;
        for (int i = 0; i < 50 && !hs; i++) begin
            hs = s_axil_arready;
            step();
            ap_done = 1'b0;
        end
        s_axil_arvalid = 1'b0;
        if (!hs) begin
            checks++; errors++;
            $display("FAIL read_timeout addr 0x%08h: AR not accepted within budget", addr);
        end else begin
            chk("read_latency_rvalid", 32'(s_axil_rvalid), 32'd1);
        end
    endtask

    // Scoreboard monitor: one pop per handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            if (s_axil_bvalid && s_axil_bready) begin
                if (bq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_b: bresp %0d with no expected response", s_axil_bresp);
                end else begin
                    chk("bresp", 32'(s_axil_bresp), 32'(bq.pop_front()));
                end
            end
            if (s_axil_rvalid && s_axil_rready) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_r: rdata 0x%08h with no expected response", s_axil_rdata);
                end else begin
                    logic [33:0] e;
                    e = rq.pop_front();
                    chk("rdata", s_axil_rdata, e[31:0]);
                    chk("rresp", 32'(s_axil_rresp), 32'(e[33:32]));
                end
            end
        end
    end

    initial begin
        // Reset values
        repeat (3) step();
        chk("rst_awready", 32'(s_axil_awready), 32'd1);
        chk("rst_wready", 32'(s_axil_wready), 32'd1);
        chk("rst_arready", 32'(s_axil_arready), 32'd1);
        chk("rst_bvalid", 32'(s_axil_bvalid), 32'd0);
        chk("rst_rvalid", 32'(s_axil_rvalid), 32'd0);
        chk("rst_rdata", s_axil_rdata, 32'd0);
        chk("rst_ap_start", 32'(ap_start), 32'd0);
        chk("rst_interrupt", 32'(interrupt), 32'd0);
        chk("rst_args", arg0 | arg1 | arg2 | arg3, 32'd0);
        reset_n = 1'b1;
        step();

        // Byte-lane masked arg write, read back
        axi_write(32'h10, 32'hDEADBEEF, 4'b0011, 2'b00, 1'b0);
        chk("arg0_masked", arg0, 32'h0000BEEF);
        axi_read(32'h10, 32'h0000BEEF, 2'b00, 1'b0);

        // W two cycles ahead of AW, B held off for 3 cycles
        step();
        s_axil_bready = 1'b0;
        s_axil_wdata = 32'h12345678; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
        step();
        s_axil_wvalid = 1'b0;
        chk("w_held_wready", 32'(s_axil_wready), 32'd0);
        chk("w_held_awready", 32'(s_axil_awready), 32'd1);
        step();
        chk("w_only_no_bvalid", 32'(s_axil_bvalid), 32'd0);
        bq.push_back(2'b00);
        s_axil_awaddr = 32'h14; s_axil_awvalid = 1'b1;
        step();
        s_axil_awvalid = 1'b0;
        chk("commit_bvalid", 32'(s_axil_bvalid), 32'd1);
        chk("commit_arg1", arg1, 32'h12345678);
        for (int i = 0; i < 3; i++) begin
            chk("bstall_bvalid", 32'(s_axil_bvalid), 32'd1);
            chk("bstall_bresp", 32'(s_axil_bresp), 32'd0);
            chk("bstall_ready", {s_axil_awready, s_axil_wready}, 32'd0);
            step();
        end
        s_axil_bready = 1'b1;
        step();
        chk("bdone_ready", {s_axil_awready, s_axil_wready}, 32'd3);
        chk("bdone_bvalid", 32'(s_axil_bvalid), 32'd0);

        // Start / ready handshake, with and without auto_restart
        axi_write(32'h00, 32'h1, 4'hF, 2'b00, 1'b0);
        chk("start_set", 32'(ap_start), 32'd1);
        pulse_ready();
        chk("start_selfclear", 32'(ap_start), 32'd0);
        axi_write(32'h00, 32'h81, 4'hF, 2'b00, 1'b0);
        pulse_ready();
        chk("start_autorestart", 32'(ap_start), 32'd1);
        axi_read(32'h00, 32'h89, 2'b00, 1'b0);
        axi_read(32'h00, 32'h81, 2'b00, 1'b0);
        axi_write(32'h00, 32'h00, 4'hF, 2'b00, 1'b0);
        chk("start_write0_noeffect", 32'(ap_start), 32'd1);
        pulse_ready();
        chk("start_clear_after_ar_off", 32'(ap_start), 32'd0);

        // Interrupt path
        ap_idle = 1'b1;
        axi_write(32'h04, 32'h1, 4'hF, 2'b00, 1'b0);
        axi_write(32'h08, 32'h1, 4'hF, 2'b00, 1'b0);
        step();
        ap_done = 1'b1;
        step();
        ap_done = 1'b0;
        chk("irq_n1", 32'(interrupt), 32'd0);
        step();
        chk("irq_n2", 32'(interrupt), 32'd1);
        axi_read(32'h0C, 32'h3, 2'b00, 1'b0);
        axi_write(32'h0C, 32'h3, 4'hF, 2'b00, 1'b0);
        chk("irq_still_registered", 32'(interrupt), 32'd1);
        step();
        chk("irq_fall", 32'(interrupt), 32'd0);
        axi_read(32'h00, 32'h0E, 2'b00, 1'b0);
        axi_read(32'h00, 32'h04, 2'b00, 1'b0);

        // Set beats clear: done pulse on the CTRL read accept edge, then on an ISR W1C
        axi_read(32'h00, 32'h04, 2'b00, 1'b1);
        axi_read(32'h00, 32'h06, 2'b00, 1'b0);
        axi_read(32'h00, 32'h04, 2'b00, 1'b0);
        axi_write(32'h0C, 32'h1, 4'hF, 2'b00, 1'b0);
        axi_read(32'h0C, 32'h0, 2'b00, 1'b0);
        axi_write(32'h0C, 32'h1, 4'hF, 2'b00, 1'b1);
        axi_read(32'h0C, 32'h1, 2'b00, 1'b0);

        // Out-of-range accesses and boundaries
        axi_read(32'h40, 32'h0, 2'b10, 1'b0);
        axi_write(32'h24, 32'hFFFFFFFF, 4'hF, 2'b10, 1'b0);
        axi_read(32'h20, 32'h0, 2'b10, 1'b0);
        axi_read(32'h13, 32'h0000BEEF, 2'b00, 1'b0);
        axi_read(32'h14, 32'h12345678, 2'b00, 1'b0);
        axi_read(32'h1C, 32'h0, 2'b00, 1'b0);
        chk("slverr_no_change", arg2 | arg3, 32'd0);
        axi_write(32'h1C, 32'hCAFEF00D, 4'hF, 2'b00, 1'b0);
        axi_read(32'h1C, 32'hCAFEF00D, 2'b00, 1'b0);

        // Async reset with a B response pending
        axi_write(32'h00, 32'h1, 4'hF, 2'b00, 1'b0);
        step();
        s_axil_bready = 1'b0;
        axi_write(32'h18, 32'hA5A5A5A5, 4'hF, 2'b00, 1'b0);
        chk("pre_rst_bvalid", 32'(s_axil_bvalid), 32'd1);
        chk("pre_rst_arg2", arg2, 32'hA5A5A5A5);
        chk("pre_rst_ap_start", 32'(ap_start), 32'd1);
        chk("pre_rst_bq_pending", 32'(bq.size()), 32'd1);
        chk("pre_rst_rq_empty", 32'(rq.size()), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("arst_bvalid", 32'(s_axil_bvalid), 32'd0);
        chk("arst_ap_start", 32'(ap_start), 32'd0);
        chk("arst_args", arg0 | arg1 | arg2 | arg3, 32'd0);
        chk("arst_awready", 32'(s_axil_awready), 32'd1);
        bq.delete();
        rq.delete();
        step();
        reset_n = 1'b1;
        s_axil_bready = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hls_pr_axil_ctrl_slave.md
# hls_pr_axil_ctrl_slave

AXI4-Lite responder that terminates the static region's AXI-Lite control master inside the HLS PR partition. It gives the host a register map for kernel start/done/idle handshake, interrupt enable/status and four 32-bit kernel arguments: source address, destination address, length and scratch. Everything runs on one clock, the PR region's kernel clock.

## Interface
- ADDR_W, 12: byte-address width compared on awaddr/araddr. Upper bits of the 32-bit bus are ignored.
- clk  in  1  kernel clock; all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- s_axil_awaddr/awprot/awvalid/awready  in/in/in/out  32/3/1/1  write address channel; prot ignored.
- s_axil_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
- s_axil_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- s_axil_araddr/arprot/arvalid/arready  in/in/in/out  32/3/1/1  read address channel; prot ignored.
- s_axil_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
- ap_start  out  1  kernel start level.
- ap_done, ap_ready  in  1 each  single-cycle kernel pulses.
- ap_idle  in  1  kernel idle level.
- arg0..arg3  out  32 each  kernel argument registers.
- interrupt  out  1  level interrupt to static region.

## Operation
Register map. Offsets are word-aligned; addr[1:0] is ignored.
- 0x00 CTRL:
  - bit0 ap_start: write 1 sets it; writing 0 has no effect. Self-clears on ap_ready unless auto_restart is set.
  - bit1 done_latch: read-only; cleared by a read of CTRL.
  - bit2 ap_idle: read-only, live value.
  - bit3 ready_latch: read-only; cleared by a read of CTRL.
  - bit7 auto_restart: read/write.
- 0x04 GIE: bit0.
- 0x08 IER: bits[1:0] = {ready, done}.
- 0x0C ISR: bits[1:0] = {ready, done}. Set by ap_ready/ap_done pulses; write 1 to clear.
- 0x10/0x14/0x18/0x1C: arg0..arg3, full read/write, byte-lane masked by wstrb.
- Offsets 0x20 and above: write ignored with bresp = SLVERR (2'b10); read returns rdata = 0 with rresp = SLVERR.
- All other responses are OKAY (2'b00).
- Unused bits read 0.

Write path, states W_IDLE → W_RESP:
- AW and W are accepted independently, in either order or together, and latched.
- awready = !aw_held & !bvalid; wready = !w_held & !bvalid.
- Once both are held, the register update commits that cycle; the FSM enters W_RESP with bvalid = 1.
- bvalid holds until bready; on the handshake cycle, clear both held flags and return to W_IDLE.

Read path, states R_IDLE → R_DATA:
- arready = !rvalid.
- On AR handshake, register the decoded data, assert rvalid next cycle, and apply clear-on-read side effects in the handshake cycle.
- rdata/rresp stay stable until rready.

Priority and boundary rules:
- Set beats clear: an ap_done/ap_ready pulse in the same cycle as a clear-on-read or an ISR W1C leaves the bit set.
- A write commit and a read accept in the same cycle: the read samples pre-write register values.
- A write of ap_start = 1 in the same cycle as an ap_ready pulse leaves ap_start = 1.
- interrupt is registered: interrupt <= GIE & |(ISR & IER).

## Timing
- Reset values: awready = 1, wready = 1, arready = 1; bvalid = 0, rvalid = 0, rdata = 0, bresp = 0, rresp = 0; ap_start = 0, interrupt = 0; all registers and latches 0.
- Write latency: AW and W both accepted at cycle N → register visible and bvalid = 1 at N+1.
- Read latency: AR accepted at cycle N → rvalid = 1 at N+1.
- Throughput is one transaction per 2 cycles per channel with bready/rready held high.
- Interrupt: status changes at cycle N → interrupt updates at N+2.
- Reset asserted mid-transaction returns all state to reset values immediately. Any pending beat is dropped and the master must re-issue.

## Test plan
- Write 0xDEADBEEF to 0x10 with wstrb = 4'b0011, then read 0x10 → rdata 0x0000BEEF, OKAY, rvalid one cycle after AR.
- Present W two cycles before AW, and hold bready low for 3 cycles → bvalid stays asserted and stable; wready/awready stay 0 until the B handshake completes.
- Write CTRL = 0x1 → ap_start = 1. Pulse ap_ready → ap_start = 0 next cycle. Repeat with auto_restart = 1 → ap_start stays 1.
- Set GIE = 1 and IER = 0x1, then pulse ap_done → ISR = 0x1 and interrupt = 1 two cycles later. Write ISR = 0x1 → interrupt falls. Read CTRL → bit1 set; a second read shows bit1 clear.
- Read 0x40 and write 0x24 → SLVERR on both, rdata 0, and no register changes.
- Assert reset_n = 0 while bvalid is pending → bvalid = 0, ap_start = 0 and all args 0, asynchronously before the next edge.
